// File: rtl/hcms_pkg.sv
// Shared types and field positions for the HCMS display serial receiver.
package hcms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int CTRL_SEL_BIT  = 7;
  localparam int CNT_W         = 11;

  // ctrl0: sleep_n | peak current | brightness
  localparam int CTRL0_BRIGHT_LSB = 0;
  localparam int CTRL0_BRIGHT_MSB = 3;
  localparam int CTRL0_PEAK_LSB   = 4;
  localparam int CTRL0_PEAK_MSB   = 5;
  localparam int CTRL0_SLEEP_BIT  = 6;
  localparam int CTRL0_W          = 7;

  localparam int CTRL1_LSB = 0;
  localparam int CTRL1_MSB = 1;
  localparam int CTRL1_W   = 2;

endpackage

// File: rtl/hcms_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from one extra history flop.
module hcms_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/hcms_serial_rx.sv
// Receiver for the HCMS dot-matrix display serial protocol: assembles dot
// bytes as they stream in and latches control words when a frame closes.
module hcms_serial_rx
  import hcms_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_DOTS    = 160
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ser_data,
  input  logic         ser_clk,
  input  logic         rs,
  input  logic         n_ce,
  input  logic         n_reset,
  output logic [7:0]   byte_data,
  output logic         byte_valid,
  output logic [7:0]   dot_index,
  output logic [CTRL0_W-1:0] ctrl0,
  output logic [CTRL1_W-1:0] ctrl1,
  output logic         ctrl_update,
  output logic         frame_err,
  output logic         busy
);

  localparam int NPINS = 5;
  localparam int P_DATA = 0, P_CLK = 1, P_RS = 2, P_NCE = 3, P_NRST = 4;
  // idle levels: n_reset, n_ce and ser_clk high; rs and ser_data low
  localparam logic [NPINS-1:0] PIN_IDLE = 5'b11010;
  localparam logic [7:0]       DOT_LAST = 8'(MAX_DOTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NPINS-1:0] pins, lvl, rise, fall;
  assign pins = {n_reset, n_ce, rs, ser_clk, ser_data};

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    hcms_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(PIN_IDLE[i])) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pins[i]),
      .level (lvl[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{rise[P_DATA], fall[P_DATA], fall[P_CLK], rise[P_RS],
                          fall[P_RS], rise[P_NRST], fall[P_NRST]};

  state_t           state;
  logic             frame_rs;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       nxt_byte;

  assign nxt_byte = {shreg[6:0], lvl[P_DATA]};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    byte_valid  <= 1'b0;
    ctrl_update <= 1'b0;
    frame_err   <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      frame_rs  <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_data <= '0;
      dot_index <= '0;
      ctrl0     <= '0;
      ctrl1     <= '0;
    end else if (!lvl[P_NRST]) begin
      // display reset: drop the frame silently and clear the control words
      state <= IDLE;
      ctrl0 <= '0;
      ctrl1 <= '0;
    end else begin
      if (byte_valid && dot_index != DOT_LAST)
        dot_index <= dot_index + 8'd1;
      case (state)
        IDLE: begin
          if (fall[P_NCE]) begin
            state     <= SHIFT;
            frame_rs  <= lvl[P_RS];
            bit_cnt   <= '0;
            dot_index <= '0;
          end
        end
        SHIFT: begin
          // a bit arriving with n_ce rising still counts toward the close check
          if (rise[P_CLK]) begin
            shreg <= nxt_byte;
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (!frame_rs && bit_cnt[2:0] == 3'(BITS_PER_BYTE - 1)) begin
                byte_data  <= nxt_byte;
                byte_valid <= 1'b1;
              end
            end
          end
          if (rise[P_NCE]) state <= CLOSE;
        end
        CLOSE: begin
          state <= IDLE;
          if (bit_cnt != '0) begin
            if (frame_rs) begin
              if (bit_cnt == CNT_W'(BITS_PER_BYTE)) begin
                if (!shreg[CTRL_SEL_BIT]) ctrl0 <= shreg[CTRL0_SLEEP_BIT:CTRL0_BRIGHT_LSB];
                else                      ctrl1 <= shreg[CTRL1_MSB:CTRL1_LSB];
                ctrl_update <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (bit_cnt[2:0] != 3'd0 || bit_cnt == CNT_MAX) begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcms_serial_rx.sv
// Directed bench for hcms_serial_rx: drives the display pins slowly and
// checks bytes, indices, control words and pulses against hand values.
module tb_hcms_serial_rx;
  logic clk, reset, ser_data, ser_clk, rs, n_ce, n_reset;
  logic [7:0] byte_data, dot_index;
  logic       byte_valid, ctrl_update, frame_err, busy;
  logic [6:0] ctrl0;
  logic [1:0] ctrl1;

  int checks = 0;
  int errors = 0;
  int bv_cnt, upd_cnt, err_cnt;
  logic [7:0] byte_log [0:255];
  logic [7:0] idx_log  [0:255];

  hcms_serial_rx #(.SYNC_STAGES(2), .MAX_DOTS(160)) dut (
    .clk(clk), .reset(reset), .ser_data(ser_data), .ser_clk(ser_clk),
    .rs(rs), .n_ce(n_ce), .n_reset(n_reset), .byte_data(byte_data),
    .byte_valid(byte_valid), .dot_index(dot_index), .ctrl0(ctrl0),
    .ctrl1(ctrl1), .ctrl_update(ctrl_update), .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      if (bv_cnt < 256) begin
        byte_log[bv_cnt] = byte_data;
        idx_log[bv_cnt]  = dot_index;
      end
      bv_cnt = bv_cnt + 1;
    end
    if (ctrl_update) upd_cnt = upd_cnt + 1;
    if (frame_err)   err_cnt = err_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    bv_cnt = 0; upd_cnt = 0; err_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    ser_clk = 1'b0; ser_data = b; cyc(6);
    ser_clk = 1'b1; cyc(6);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic open_frame(input logic r);
    rs = r; cyc(2); n_ce = 1'b0; cyc(6);
  endtask

  task automatic close_frame();
    n_ce = 1'b1; cyc(10);
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(4); reset = 1'b0; cyc(4);
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data got %h want 00", byte_data); end
    checks++; if (dot_index !== 8'h00) begin errors++; $display("FAIL reset_dot_index got %h want 00", dot_index); end
    checks++; if ({ctrl0, ctrl1} !== 9'h000) begin errors++; $display("FAIL reset_ctrl got %h/%h want 0/0", ctrl0, ctrl1); end
    checks++; if ({busy, byte_valid, ctrl_update, frame_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, byte_valid, ctrl_update, frame_err}); end
  endtask

  task automatic test_ctrl1();
    clear_counts();
    open_frame(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ctrl1_busy got %b want 1", busy); end
    send_bits(8'h81, 8); close_frame();
    checks++; if (ctrl1 !== 2'b01) begin errors++; $display("FAIL ctrl1_value got %b want 01", ctrl1); end
    checks++; if (ctrl0 !== 7'h00) begin errors++; $display("FAIL ctrl1_ctrl0_kept got %h want 00", ctrl0); end
    checks++; if (upd_cnt !== 1 || bv_cnt !== 0 || err_cnt !== 0) begin
      errors++; $display("FAIL ctrl1_pulses upd=%0d bv=%0d err=%0d want 1/0/0", upd_cnt, bv_cnt, err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ctrl1_idle got %b want 0", busy); end
  endtask

  task automatic test_ctrl0_nreset();
    clear_counts();
    open_frame(1'b1); send_bits(8'h79, 8); close_frame();
    checks++; if (ctrl0 !== 7'h79 || ctrl1 !== 2'b01) begin
      errors++; $display("FAIL ctrl0_value got %h/%b want 79/01", ctrl0, ctrl1); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL ctrl0_update got %0d want 1", upd_cnt); end
    n_reset = 1'b0; cyc(10); n_reset = 1'b1; cyc(6);
    checks++; if (ctrl0 !== 7'h00 || ctrl1 !== 2'b00) begin
      errors++; $display("FAIL nreset_clear got %h/%b want 00/00", ctrl0, ctrl1); end
  endtask

  task automatic test_dot_frame();
    logic [7:0] v [0:3];
    v[0] = 8'h00; v[1] = 8'h01; v[2] = 8'hFF; v[3] = 8'hA5;
    clear_counts();
    open_frame(1'b0);
    for (int i = 0; i < 4; i++) send_bits(v[i], 8);
    close_frame();
    checks++; if (bv_cnt !== 4 || err_cnt !== 0 || upd_cnt !== 0) begin
      errors++; $display("FAIL dot_pulses bv=%0d err=%0d upd=%0d want 4/0/0", bv_cnt, err_cnt, upd_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (byte_log[i] !== v[i] || idx_log[i] !== 8'(i)) begin
        errors++; $display("FAIL dot_byte%0d got %h@%0d want %h@%0d", i, byte_log[i], idx_log[i], v[i], i); end
    end
  endtask

  task automatic test_bad_counts();
    clear_counts();
    open_frame(1'b1); send_bits(8'h55, 8); close_frame();
    checks++; if (ctrl0 !== 7'h55) begin errors++; $display("FAIL bad_setup_ctrl0 got %h want 55", ctrl0); end
    clear_counts();
    open_frame(1'b1); send_bits(8'h2A, 7); close_frame();
    checks++; if (err_cnt !== 1 || upd_cnt !== 0) begin
      errors++; $display("FAIL ctrl7_err err=%0d upd=%0d want 1/0", err_cnt, upd_cnt); end
    checks++; if (ctrl0 !== 7'h55 || ctrl1 !== 2'b00) begin
      errors++; $display("FAIL ctrl7_kept got %h/%b want 55/00", ctrl0, ctrl1); end
    clear_counts();
    open_frame(1'b0); send_bits(8'hC3, 8); send_bits(8'hF0, 4); close_frame();
    checks++; if (err_cnt !== 1 || bv_cnt !== 1 || byte_log[0] !== 8'hC3) begin
      errors++; $display("FAIL dot12 err=%0d bv=%0d byte=%h want 1/1/c3", err_cnt, bv_cnt, byte_log[0]); end
  endtask

  task automatic test_reset_abort();
    clear_counts();
    open_frame(1'b0); send_bits(8'hA0, 4);
    reset = 1'b1; n_ce = 1'b1; cyc(3); reset = 1'b0; cyc(6);
    checks++; if (bv_cnt !== 0 || err_cnt !== 0 || upd_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet bv=%0d err=%0d upd=%0d busy=%b want 0/0/0/0", bv_cnt, err_cnt, upd_cnt, busy); end
    open_frame(1'b0); send_bits(8'h3C, 8); close_frame();
    checks++; if (bv_cnt !== 1 || byte_log[0] !== 8'h3C || idx_log[0] !== 8'd0 || err_cnt !== 0) begin
      errors++; $display("FAIL abort_next bv=%0d byte=%h idx=%0d err=%0d want 1/3c/0/0", bv_cnt, byte_log[0], idx_log[0], err_cnt); end
  endtask

  task automatic test_saturation();
    clear_counts();
    open_frame(1'b0);
    for (int i = 0; i < 162; i++) send_bits(8'(i), 8);
    close_frame();
    checks++; if (bv_cnt !== 162 || err_cnt !== 0) begin
      errors++; $display("FAIL sat_count bv=%0d err=%0d want 162/0", bv_cnt, err_cnt); end
    checks++; if (idx_log[158] !== 8'd158 || idx_log[159] !== 8'd159) begin
      errors++; $display("FAIL sat_edge got %0d,%0d want 158,159", idx_log[158], idx_log[159]); end
    checks++; if (idx_log[161] !== 8'd159 || byte_log[161] !== 8'd161) begin
      errors++; $display("FAIL sat_hold idx=%0d byte=%0d want 159/161", idx_log[161], byte_log[161]); end
  endtask

  task automatic test_idle_ignore();
    logic [7:0] bd, di;
    logic [6:0] c0;
    logic [1:0] c1;
    bd = byte_data; di = dot_index; c0 = ctrl0; c1 = ctrl1;
    clear_counts();
    for (int i = 0; i < 16; i++) begin rs = i[0]; send_bit(i[1]); end
    rs = 1'b0; cyc(6);
    checks++; if (bv_cnt !== 0 || err_cnt !== 0 || upd_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_pulses bv=%0d err=%0d upd=%0d busy=%b want 0/0/0/0", bv_cnt, err_cnt, upd_cnt, busy); end
    checks++; if (byte_data !== bd || dot_index !== di || ctrl0 !== c0 || ctrl1 !== c1) begin
      errors++; $display("FAIL idle_outputs got %h/%0d/%h/%b want %h/%0d/%h/%b", byte_data, dot_index, ctrl0, ctrl1, bd, di, c0, c1); end
  endtask

  initial begin
    reset = 1'b1; ser_data = 1'b0; ser_clk = 1'b1; rs = 1'b0; n_ce = 1'b1; n_reset = 1'b1;
    clear_counts();
    test_reset();
    test_ctrl1();
    test_ctrl0_nreset();
    test_dot_frame();
    test_bad_counts();
    test_reset_abort();
    test_saturation();
    test_idle_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hcms_serial_rx.md
HCMS_SERIAL_RX -- requirements
Module: hcms_serial_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per pin input (minimum 2).
REQ-002 SHALL have parameter MAX_DOTS, default 160, dot-byte index limit; index saturates at MAX_DOTS-1.
REQ-003 SHALL have ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ser_data  in  1  display serial data pin, asynchronous.
- ser_clk  in  1  display serial clock pin, asynchronous, idle high.
- rs  in  1  register select pin: 1 = control, 0 = dot.
- n_ce  in  1  chip enable pin, active-low.
- n_reset  in  1  display reset pin, active-low.
- byte_data  out  8  last assembled byte, MSB first on the wire.
- byte_valid  out  1  one-cycle pulse: byte_data holds a new dot byte.
- dot_index  out  8  index of the byte in byte_data within the current frame.
- ctrl0  out  7  control word 0, bits D6..D0: sleep_n, peak current[1:0], brightness[3:0].
- ctrl1  out  2  control word 1, bits D1..D0.
- ctrl_update  out  1  one-cycle pulse: ctrl0 or ctrl1 was written.
- frame_err  out  1  one-cycle pulse: frame closed with a bad bit count.
- busy  out  1  high while a frame is open (synchronized n_ce low).

Function
REQ-004 Each pin input SHALL pass through SYNC_STAGES flops plus one edge-history flop; all logic SHALL use only the synchronized values.
REQ-005 ser_clk high and low phases SHALL each last at least 4 clk periods; shorter phases are outside the supported range, and behaviour for them is undefined.
REQ-006 FSM states SHALL be IDLE, SHIFT and CLOSE, reset to IDLE.
REQ-007 IDLE->SHIFT SHALL occur on a synchronized n_ce falling edge. On that edge: rs latched into frame_rs, bit counter = 0, dot_index = 0.
REQ-008 In SHIFT, each synchronized ser_clk rising edge SHALL shift ser_data into an 8-bit shift register (MSB first) and increment the bit counter.
REQ-009 In SHIFT with frame_rs=0, on every 8th bit: byte_data <= assembled byte; byte_valid pulses 1 cycle later than that ser_clk edge is detected; dot_index advances after each pulse, saturating at MAX_DOTS-1.
REQ-010 SHIFT->CLOSE SHALL occur on a synchronized n_ce rising edge; CLOSE SHALL last exactly 1 cycle and then go to IDLE.
REQ-011 CLOSE with frame_rs=1 and exactly 8 bits received: if byte[7]=0 then ctrl0 <= byte[6:0], else ctrl1 <= byte[1:0]; ctrl_update pulses.
REQ-012 CLOSE with frame_rs=1 and a bit count other than 8 SHALL pulse frame_err; ctrl0 and ctrl1 remain unchanged.
REQ-013 CLOSE with frame_rs=0 and a bit count not a multiple of 8 SHALL pulse frame_err; a trailing partial byte SHALL be discarded.
REQ-014 A frame with zero bits SHALL produce no pulse of any kind.
REQ-015 The bit counter SHALL be 11 bits wide and saturate at all-ones; a saturated count SHALL be treated as an error at CLOSE.
REQ-016 ser_clk edges and rs changes while in IDLE SHALL be ignored.
REQ-017 If a ser_clk rise and an n_ce rise are detected in the same cycle, the bit SHALL be shifted first and then evaluated at CLOSE.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 reset SHALL set: state = IDLE, byte_data = 0, dot_index = 0, ctrl0 = 0, ctrl1 = 0, all pulses = 0, synchronizers = idle levels (ser_clk 1, n_ce 1, n_reset 1).
REQ-020 Synchronized n_reset low SHALL force: ctrl0 = 0, ctrl1 = 0, state = IDLE, and abort any open frame with no pulses. Reception SHALL remain blocked until n_reset returns high and a new n_ce falling edge occurs.
REQ-021 reset asserted mid-frame SHALL abort the frame with no pulses in the following cycle.

Structure
REQ-022 Package hcms_pkg SHALL hold: the FSM state enum, the ctrl0/ctrl1 field bit positions, the CTRL_SEL_BIT=7 constant, and the BITS_PER_BYTE=8 constant.
REQ-023 A sub-module hcms_sync_edge (synchronizer, rise/fall pulses, reset-value parameter) SHALL be instantiated once per pin input.

Verification
REQ-024 Control frame rs=1, byte 0x81 -> ctrl1=2'b01, ctrl0 unchanged, exactly one ctrl_update pulse, no byte_valid.
REQ-025 Control frame rs=1, byte 0x79 -> ctrl0=7'h79, ctrl_update once; then n_reset low for 10 cycles -> ctrl0=0, ctrl1=0.
REQ-026 Dot frame rs=0, bytes 0x00,0x01,0xFF,0xA5 -> 4 byte_valid pulses with matching byte_data and dot_index 0..3, no frame_err.
REQ-027 Control frame with 7 bits, and dot frame with 12 bits -> frame_err once each; ctrl unchanged; dot frame yields exactly 1 byte_valid.
REQ-028 reset asserted after 4 bits of a dot frame, then a clean 0x3C dot frame -> no pulse from the aborted frame; byte_valid with 0x3C at dot_index 0.
REQ-029 Dot frame of 162 bytes -> dot_index saturates at 159; ser_clk toggling while n_ce high -> no outputs change.
